// File: rtl/add_arb_pkg.sv
// add_arb_pkg: shared definitions for the add_arbiter block.
//   ADD_WIDTH  - default operand/sum width
//   state_e    - output register state (ST_EMPTY / ST_FULL)
//   rr_winner  - round-robin pick: first valid index at or above ptr,
//                wrapping modulo nreq; returns -1 when nothing is valid.
package add_arb_pkg;

  localparam int ADD_WIDTH = 32;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // valid is zero-extended to 8 bits so one function serves NREQ = 2..8.
  function automatic int rr_winner(input logic [7:0] valid, input int ptr, input int nreq);
    int win;
    int idx;
    win = -1;
    for (int k = 0; k < 8; k++) begin
      if (k < nreq && win < 0) begin
        idx = (ptr + k) % nreq;
        if (|(valid & (8'd1 << idx))) win = idx;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/add32_core.sv
// add32_core: combinational Kogge-Stone adder built from kpg, ppc and
// fulladder stages.
//   a, b : operands
//   cin  : carry-in
//   sum  : a + b + cin (low WIDTH bits)
//   cout : carry out of the MSB
module add32_core
  import add_arb_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LV = $clog2(WIDTH);

  logic [WIDTH-1:0] g_bit, p_bit;
  logic [WIDTH-1:0] carry;
  logic             unused_p;

  kpg #(.WIDTH(WIDTH)) u_kpg (
    .a_i(a), .b_i(b), .g_o(g_bit), .p_o(p_bit)
  );

  genvar l, i;
  generate
    for (l = 0; l <= LV; l++) begin : g_lvl
      logic [WIDTH-1:0] g, p;
      if (l == 0) begin : g_base
        // Fold cin into bit 0 so every group generate below already
        // includes the carry-in; group G[i] is then the carry into bit i+1.
        ppc u_cin (
          .gh_i(g_bit[0]), .ph_i(p_bit[0]), .gl_i(cin), .pl_i(1'b0),
          .g_o(g[0]), .p_o(p[0])
        );
        assign g[WIDTH-1:1] = g_bit[WIDTH-1:1];
        assign p[WIDTH-1:1] = p_bit[WIDTH-1:1];
      end else begin : g_tree
        for (i = 0; i < WIDTH; i++) begin : g_node
          if (i >= (1 << (l - 1))) begin : g_cell
            ppc u_ppc (
              .gh_i(g_lvl[l-1].g[i]),
              .ph_i(g_lvl[l-1].p[i]),
              .gl_i(g_lvl[l-1].g[i - (1 << (l - 1))]),
              .pl_i(g_lvl[l-1].p[i - (1 << (l - 1))]),
              .g_o (g[i]),
              .p_o (p[i])
            );
          end else begin : g_pass
            assign g[i] = g_lvl[l-1].g[i];
            assign p[i] = g_lvl[l-1].p[i];
          end
        end
      end
    end
  endgenerate

  assign carry    = {g_lvl[LV].g[WIDTH-2:0], cin};
  assign cout     = g_lvl[LV].g[WIDTH-1];
  assign unused_p = ^g_lvl[LV].p;

  fulladder #(.WIDTH(WIDTH)) u_fa (
    .a_i(a), .b_i(b), .c_i(carry), .s_o(sum)
  );

endmodule

// File: rtl/fulladder.sv
// fulladder: final sum stage, one bit per lane.
//   a_i, b_i : operands
//   c_i      : carry into each bit position
//   s_o      : sum bits
module fulladder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] s_o
);

  assign s_o = a_i ^ b_i ^ c_i;

endmodule

// File: rtl/kpg.sv
// kpg: per-bit generate/propagate stage of the prefix adder.
//   a_i, b_i : operands
//   g_o      : a & b (generate)
//   p_o      : a ^ b (propagate)
module kpg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] g_o,
  output logic [WIDTH-1:0] p_o
);

  assign g_o = a_i & b_i;
  assign p_o = a_i ^ b_i;

endmodule

// File: rtl/ppc.sv
// ppc: one parallel-prefix combine node (black cell).
//   gh_i, ph_i : generate/propagate of the upper group
//   gl_i, pl_i : generate/propagate of the lower group
//   g_o, p_o   : combined group generate/propagate
module ppc (
  input  logic gh_i,
  input  logic ph_i,
  input  logic gl_i,
  input  logic pl_i,
  output logic g_o,
  output logic p_o
);

  assign g_o = gh_i | (ph_i & gl_i);
  assign p_o = ph_i & pl_i;

endmodule

// File: rtl/add_arbiter.sv
// add_arbiter: round-robin sharing of one prefix adder between NREQ
// requesters, result held in a single tagged output register.
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : per-requester handshake (ready one-hot or zero)
//   req_a, req_b        : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin             : per-requester carry-in
//   req_sub             : per-requester subtract (only with ADD_ARB_SUB_EN)
//   res_valid/res_ready : result handshake
//   res_sum, res_cout, res_ovf, res_id : registered result and source tag
// Optional feature macro: ADD_ARB_SUB_EN (adds req_sub and subtract support).
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter  int WIDTH = ADD_WIDTH,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
`ifdef ADD_ARB_SUB_EN
  input  logic [NREQ-1:0]       req_sub,
`endif
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_sum,
  output logic                  res_cout,
  output logic                  res_ovf,
  output logic [IDW-1:0]        res_id
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [IDW-1:0]   id_q, id_d;

  int               sel_raw, sel;
  logic             found;
  logic [NREQ-1:0]  sel_oh;
  logic             can_accept, xfer;

  logic [WIDTH-1:0] op_a, op_b, op_b_eff, add_sum;
  logic             cin_sel, cin_eff, add_cout;

  // Arbitration depends only on valids and the pointer, never on operands.
  always_comb begin
    sel_raw = rr_winner(8'(req_valid), int'(ptr_q), NREQ);
    found   = (sel_raw >= 0);
    sel     = found ? sel_raw : 0;
    sel_oh  = NREQ'(1) << sel;
  end

  // rst gates acceptance so nothing is granted while reset is held.
  assign can_accept = !rst && ((state_q == ST_EMPTY) || res_ready);
  assign xfer       = found && can_accept;

  assign op_a    = WIDTH'(req_a >> (sel * WIDTH));
  assign op_b    = WIDTH'(req_b >> (sel * WIDTH));
  assign cin_sel = |(req_cin & sel_oh);

`ifdef ADD_ARB_SUB_EN
  logic sub_sel;
  assign sub_sel  = |(req_sub & sel_oh);
  assign op_b_eff = sub_sel ? ~op_b : op_b;
  assign cin_eff  = sub_sel | cin_sel;
`else
  assign op_b_eff = op_b;
  assign cin_eff  = cin_sel;
`endif

  add32_core #(.WIDTH(WIDTH)) u_core (
    .a(op_a), .b(op_b_eff), .cin(cin_eff), .sum(add_sum), .cout(add_cout)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (xfer) state_d = ST_FULL;
      ST_FULL:  if (xfer) state_d = ST_FULL;
                else if (res_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Output logic
  always_comb begin
    res_valid = (state_q == ST_FULL);
    req_ready = xfer ? sel_oh : '0;
  end

  // Result and pointer registers load only on a transfer.
  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    id_d   = id_q;
    ptr_d  = ptr_q;
    if (xfer) begin
      sum_d  = add_sum;
      cout_d = add_cout;
      ovf_d  = (op_a[WIDTH-1] == op_b_eff[WIDTH-1]) && (add_sum[WIDTH-1] != op_a[WIDTH-1]);
      id_d   = IDW'(sel);
      ptr_d  = IDW'((sel + 1) % NREQ);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      id_q   <= '0;
      ptr_q  <= '0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      id_q   <= id_d;
      ptr_q  <= ptr_d;
    end
  end

  assign res_sum  = sum_q;
  assign res_cout = cout_q;
  assign res_ovf  = ovf_q;
  assign res_id   = id_q;

endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: directed self-checking bench for add_arbiter.
// Subtraction vectors are included when ADD_ARB_SUB_EN is defined.
module tb_add_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
`ifdef ADD_ARB_SUB_EN
  logic [NREQ-1:0]       req_sub;
`endif
  logic                  res_valid;
  logic                  res_ready;
  logic [WIDTH-1:0]      res_sum;
  logic                  res_cout;
  logic                  res_ovf;
  logic [IDW-1:0]        res_id;

  int errors = 0;
  int checks = 0;

  add_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_cin  (req_cin),
`ifdef ADD_ARB_SUB_EN
    .req_sub  (req_sub),
`endif
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_sum  (res_sum),
    .res_cout (res_cout),
    .res_ovf  (res_ovf),
    .res_id   (res_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic cin);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_cin[i]              = cin;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    res_ready = 1'b0;
`ifdef ADD_ARB_SUB_EN
    req_sub   = '0;
`endif
    step();
    step();

    // Reset state, and no grant while rst is high
    req_valid = 4'b0001;
    #1;
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_sum",   64'(res_sum),   64'd0);
    chk("rst_cout",  64'(res_cout),  64'd0);
    chk("rst_ovf",   64'(res_ovf),   64'd0);
    chk("rst_id",    64'(res_id),    64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    step();
    rst = 1'b0;

    // Single add
    set_req(0, 32'hC090F0D0, 32'hCF00FADB, 1'b1);
    req_valid = 4'b0001;
    #1;
    chk("add_ready", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    chk("add_valid", 64'(res_valid), 64'd1);
    chk("add_sum",   64'(res_sum),   64'h8F91EBAC);
    chk("add_cout",  64'(res_cout),  64'd1);
    chk("add_ovf",   64'(res_ovf),   64'd0);
    chk("add_id",    64'(res_id),    64'd0);

    // Signed overflow, then carry-out
    res_ready = 1'b1;
    set_req(2, 32'h7FFFFFFF, 32'h00000001, 1'b0);
    req_valid = 4'b0100;
    #1;
    chk("ovf_ready", 64'(req_ready), 64'b0100);
    step();
    chk("ovf_sum",  64'(res_sum),  64'h80000000);
    chk("ovf_cout", 64'(res_cout), 64'd0);
    chk("ovf_ovf",  64'(res_ovf),  64'd1);
    chk("ovf_id",   64'(res_id),   64'd2);
    set_req(3, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    req_valid = 4'b1000;
    #1;
    chk("co_ready", 64'(req_ready), 64'b1000);
    step();
    req_valid = '0;
    chk("co_sum",  64'(res_sum),  64'd0);
    chk("co_cout", 64'(res_cout), 64'd1);
    chk("co_ovf",  64'(res_ovf),  64'd0);
    chk("co_id",   64'(res_id),   64'd3);

    // Drain with no new request: EMPTY, registers hold
    step();
    chk("drain_valid", 64'(res_valid), 64'd0);
    chk("drain_id",    64'(res_id),    64'd3);
    chk("drain_cout",  64'(res_cout),  64'd1);

    // Round robin, all valid, consumer always ready
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i * 256), 32'(i), 1'b0);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      step();
      chk("rr_valid", 64'(res_valid), 64'd1);
      chk("rr_id",    64'(res_id),    64'(k % 4));
      chk("rr_sum",   64'(res_sum),   64'((k % 4) * 257));
    end

    // Backpressure: result from req0 (sum 0) held for 3 cycles
    res_ready = 1'b0;
    set_req(1, 32'h11111111, 32'h22222222, 1'b1);
    req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_valid", 64'(res_valid), 64'd1);
      chk("bp_id",    64'(res_id),    64'd0);
      chk("bp_sum",   64'(res_sum),   64'd0);
      step();
    end
    res_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(req_ready), 64'b0010);
    step();
    chk("bp_next_valid", 64'(res_valid), 64'd1);
    chk("bp_next_id",    64'(res_id),    64'd1);
    chk("bp_next_sum",   64'(res_sum),   64'h33333334);

    // Pointer now 2: a lone req0 still wins by wrap-around; pointer becomes 1
    set_req(0, 32'h10, 32'h20, 1'b0);
    req_valid = 4'b0001;
    #1;
    chk("wrap_ready", 64'(req_ready), 64'b0001);
    step();
    chk("wrap_id",  64'(res_id),  64'd0);
    chk("wrap_sum", 64'(res_sum), 64'h30);

    // Reset while FULL; pointer must return to 0 so req0 beats req1
    res_ready = 1'b0;
    req_valid = 4'b0011;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_sum",   64'(res_sum),   64'd0);
    step();
    rst = 1'b0;
    res_ready = 1'b1;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'b0001);
    step();
    chk("post_rst_valid", 64'(res_valid), 64'd1);
    chk("post_rst_id",    64'(res_id),    64'd0);
    chk("post_rst_sum",   64'(res_sum),   64'h30);

`ifdef ADD_ARB_SUB_EN
    // Subtract: 5 - 7, cin ignored
    set_req(1, 32'd5, 32'd7, 1'b0);
    req_sub   = 4'b0010;
    req_valid = 4'b0010;
    #1;
    chk("sub_ready", 64'(req_ready), 64'b0010);
    step();
    req_valid = '0;
    req_sub   = '0;
    chk("sub_sum",  64'(res_sum),  64'hFFFFFFFE);
    chk("sub_cout", 64'(res_cout), 64'd0);
    chk("sub_ovf",  64'(res_ovf),  64'd0);
    chk("sub_id",   64'(res_id),   64'd1);
`endif

    req_valid = '0;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_arbiter.md
# add_arbiter

Shares one 32-bit parallel-prefix adder core between up to `NREQ` requesters. Each cycle, round-robin arbitration selects one pending request. The operands go through the combinational prefix adder, and the result is captured in a single output register tagged with the requester index. The block sits between client datapaths (ALU ports, address generators) and the shared adder, and provides valid/ready handshakes on both sides.

## Interface
- `WIDTH`, 32: operand and sum width.
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, `$clog2(NREQ)`: width of the result tag (localparam).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; **one clock; reset is asynchronous and active-high**.
- `req_valid`  in  NREQ  per-requester request pending.
- `req_ready`  out  NREQ  grant/accept, one-hot or zero.
- `req_a`  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- `req_b`  in  NREQ*WIDTH  operand B, same packing.
- `req_cin`  in  NREQ  carry-in per requester.
- `req_sub`  in  NREQ  subtract select; present only with `ADD_ARB_SUB_EN`.
- `res_valid`  out  1  result register holds a result.
- `res_ready`  in  1  consumer accepts the result.
- `res_sum`  out  WIDTH  registered sum.
- `res_cout`  out  1  registered carry-out (bit WIDTH of the sum).
- `res_ovf`  out  1  registered signed overflow.
- `res_id`  out  IDW  index of the requester that produced the result.

## Operation
- Output FSM has two states, EMPTY (`res_valid`=0) and FULL (`res_valid`=1).
- `can_accept` = EMPTY | (FULL & `res_ready`).
- Arbitration is combinational and round-robin.
  - Priority pointer `ptr`: search from `ptr` upward, wrapping modulo NREQ; the first i with `req_valid[i]` wins.
  - `req_ready[winner]` = `can_accept`; all other `req_ready` bits are 0.
- Transfer on requester i happens when `req_valid[i] & req_ready[i]`. At that edge:
  - `res_sum`/`res_cout` take the adder result of `req_a[i] + req_b[i] + req_cin[i]`.
  - `res_ovf` = (a[MSB] == b'[MSB]) & (sum[MSB] != a[MSB]), where b' is the operand actually presented to the adder.
  - `res_id` = i; `ptr` = (i+1) mod NREQ; state becomes FULL.
- FULL & `res_ready` with no transfer: state becomes EMPTY. Result registers hold their values, and `ptr` is unchanged.
- FULL & `res_ready` with a transfer in the same cycle: state stays FULL and the registers load the new result. Throughput is 1 result per cycle.
- FULL & !`res_ready`: all `req_ready` are 0 and the registers hold.
- Requesters hold `req_valid` and operands stable until accepted. Dropping `req_valid` before acceptance is permitted; that requester is simply not considered.
- Reset values: `res_valid`=0, `res_sum`=0, `res_cout`=0, `res_ovf`=0, `res_id`=0, `ptr`=0, state EMPTY.
- Reset asserted mid-operation: the pending result is discarded, and `req_ready` is 0 while `rst`=1.

## Timing
- Latency is 1 cycle: a transfer at edge N gives `res_valid`=1 with the result after edge N.
- `req_ready` depends combinationally on `req_valid`, `res_ready` and state. There is no combinational path from `req_a`/`req_b` to any output.
- The adder path (operand mux, then prefix adder, then register) must close in one cycle at WIDTH=32.
- Fairness: with all NREQ requesters continuously valid and `res_ready`=1, grants rotate 0,1,..,NREQ-1,0,.. A requester waits at most NREQ-1 grants.

## Configuration
- `ADD_ARB_SUB_EN` defined:
  - The `req_sub` port exists.
  - When `req_sub[i]`=1: b' = ~`req_b[i]`, the effective carry-in is forced to 1, and `req_cin[i]` is ignored. `res_cout`=1 means no borrow.
- Not defined:
  - No `req_sub` port.
  - b' = `req_b[i]`, and carry-in = `req_cin[i]`.

## Structure
- Shared package `add_arb_pkg` holds:
  - `WIDTH` default and state encoding `ST_EMPTY`=0, `ST_FULL`=1.
  - A function computing the round-robin winner from a valid vector and `ptr`.
- One sub-module, `add32_core`: a combinational wrapper instantiating the existing `kpg`, `ppc` and `fulladder` stages. Ports: a, b, cin → sum, cout.

## Test plan
- **Single add.** After reset, req0 a=0xC090F0D0, b=0xCF00FADB, cin=1. Expect `req_ready[0]` same cycle; next cycle `res_valid`=1, sum=0x8F91EBAC, cout=1, ovf=0, id=0.
- **Signed overflow and carry-out.** req2 a=0x7FFFFFFF, b=0x00000001, cin=0 → sum=0x80000000, cout=0, ovf=1, id=2. Then req3 a=0xFFFFFFFF, b=0x00000001 → sum=0, cout=1, ovf=0.
- **Round robin.** All 4 requesters valid, `res_ready`=1 → ids 0,1,2,3,0 on consecutive cycles, `res_valid` continuously 1.
- **Backpressure.** Result held with `res_ready`=0 for 3 cycles → `req_ready`=0 and `res_*` stable. Raising `res_ready` with req1 valid loads req1's result the next cycle, with no bubble.
- **Reset mid-flight.** `rst` pulsed asynchronously while FULL → `res_valid`=0 immediately. After release, req1 and req0 both valid → req0 wins (`ptr`=0).
- **Subtraction (`ADD_ARB_SUB_EN`).** req1 sub=1, a=5, b=7, cin=0 → sum=0xFFFFFFFE, cout=0, ovf=0.
